dco_period_meter: RTL and testbench

- Receive-side companion to the DCO: measures the half-period of a DCO square wave in `clk` cycles.
- Decodes the measured period back into the representative 8-bit one-hot control code that produces it.
- Reports lock, validity and stall status.
- Sits beside the DCO on the same `clk` for loopback self-test and for closed-loop tuning logic.

---
 rtl/dco_pkg.sv | 38 +++
 rtl/dco_period_meter_sync.sv | 27 ++
 rtl/dco_period_meter.sv | 103 ++++++++++
 tb/tb_dco_period_meter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared DCO definitions: code width, period landmarks, period->code map.
// Used by both the DCO and the period meter so the two maps stay aligned.
package dco_pkg;

  localparam int DCO_CODE_W = 8;

  localparam logic [7:0] P_MIN  = 8'd3;
  localparam logic [7:0] P_MAX  = 8'd10;
  localparam logic [7:0] P_ZERO = 8'd50;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    LOCKING,
    LOCKED
  } meter_state_t;

  typedef struct packed {
    logic                  ok;
    logic [DCO_CODE_W-1:0] code;
  } code_dec_t;

  // One-hot bit n <-> half-period P_MIN+n; P_ZERO is the all-off code.
  function automatic code_dec_t period_to_code(input logic [7:0] p);
    code_dec_t d;
    d.ok   = 1'b1;
    d.code = '0;
    unique case (1'b1)
      (p >= P_MIN) && (p <= P_MAX):
        d.code = DCO_CODE_W'(1) << (p - P_MIN);
      p == P_ZERO: ;
      default:
        d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dco_period_meter_sync.sv
// Synchroniser for dco_in plus registered both-edge detector.
// The edge pulse lands one cycle after the synchronised level changes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

endmodule

// File: rtl/dco_period_meter.sv
// Measures DCO half-period in clk cycles and decodes it to the DCO code.
// Tracks lock over repeated equal measurements and flags stalls.
module dco_period_meter
  import dco_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 200,
  parameter int LOCK_COUNT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dco_in,
  output logic [7:0]            period_out,
  output logic [DCO_CODE_W-1:0] code_out,
  output logic                  code_valid,
  output logic                  locked,
  output logic                  meas_strobe,
  output logic                  bad_period,
  output logic                  stalled
);

  logic         edge_pulse;
  logic [7:0]   cnt;
  logic [3:0]   match_cnt;
  logic [3:0]   match_nxt;
  logic         lock_nxt;
  meter_state_t state;
  code_dec_t    dec;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .din       (dco_in),
    .edge_pulse(edge_pulse)
  );

  assign dec = period_to_code(cnt);

  // ARM marks the first measurement: nothing valid to compare against yet.
  always_comb begin
    match_nxt = 4'd1;
    if ((state != ARM) && (cnt == period_out))
      match_nxt = (match_cnt == 4'd15) ? match_cnt : match_cnt + 4'd1;
  end

  assign lock_nxt = match_nxt >= 4'(LOCK_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      match_cnt   <= '0;
      period_out  <= '0;
      code_out    <= '0;
      code_valid  <= 1'b0;
      locked      <= 1'b0;
      meas_strobe <= 1'b0;
      bad_period  <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      meas_strobe <= 1'b0;
      bad_period  <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        cnt        <= '0;
        match_cnt  <= '0;
        locked     <= 1'b0;
        code_valid <= 1'b0;
        stalled    <= 1'b0;
      end else if (state == IDLE) begin
        cnt <= '0;
        if (edge_pulse) begin
          state   <= ARM;
          stalled <= 1'b0;
        end
      end else if (edge_pulse) begin
        cnt         <= '0;
        period_out  <= cnt;
        meas_strobe <= 1'b1;
        bad_period  <= !dec.ok;
        if (dec.ok)
          code_out <= dec.code;
        match_cnt  <= match_nxt;
        state      <= lock_nxt ? LOCKED : LOCKING;
        locked     <= lock_nxt;
        code_valid <= lock_nxt && dec.ok;
      end else if (cnt == 8'(TIMEOUT)) begin
        state      <= IDLE;
        cnt        <= '0;
        match_cnt  <= '0;
        stalled    <= 1'b1;
        locked     <= 1'b0;
        code_valid <= 1'b0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dco_period_meter.sv
// Self-checking bench for dco_period_meter: directed scenarios plus
// randomized toggle bursts checked by a scoreboard of toggle spacings.
module tb_dco_period_meter;

  localparam int TO = 200;
  localparam int LC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dco_in;
  logic [7:0] period_out;
  logic [7:0] code_out;
  logic       code_valid;
  logic       locked;
  logic       meas_strobe;
  logic       bad_period;
  logic       stalled;

  dco_period_meter #(
    .SYNC_STAGES(2),
    .TIMEOUT    (TO),
    .LOCK_COUNT (LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dco_in     (dco_in),
    .period_out (period_out),
    .code_out   (code_out),
    .code_valid (code_valid),
    .locked     (locked),
    .meas_strobe(meas_strobe),
    .bad_period (bad_period),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected P per measured interval.
  int         exp_q[$];
  bit         armed = 0;
  int         last_cyc = 0;
  bit         have_prev = 0;
  int         prev_p = 0;
  int         run = 0;
  logic [7:0] last_code = 8'h00;

  function automatic bit ref_ok(int p);
    return (p >= 3 && p <= 10) || p == 50;
  endfunction

  function automatic logic [7:0] ref_code(int p);
    case (p)
      10: return 8'h80;
      9:  return 8'h40;
      8:  return 8'h20;
      7:  return 8'h10;
      6:  return 8'h08;
      5:  return 8'h04;
      4:  return 8'h02;
      3:  return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mon_loop();
    int p;
    bit ok;
    bit lk;
    forever begin
      @(negedge clk);
      if (meas_strobe === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: period_out=%0d, no strobe required",
                   period_out);
        end else begin
          p = exp_q.pop_front();
          if (have_prev && p == prev_p)
            run = (run < 15) ? run + 1 : 15;
          else
            run = 1;
          have_prev = 1;
          prev_p    = p;
          ok = ref_ok(p);
          lk = (run >= LC);
          if (ok) last_code = ref_code(p);
          n_cmp++;
          if ({period_out, code_out, locked, code_valid, bad_period} !==
              {8'(p), last_code, lk, lk && ok, !ok}) begin
            n_bad++;
            $display("FAIL scoreboard: got P=%0d code=%h lk=%b cv=%b bad=%b, need P=%0d code=%h lk=%b cv=%b bad=%b",
                     period_out, code_out, locked, code_valid, bad_period,
                     p, last_code, lk, lk && ok, !ok);
          end
        end
      end
    end
  endtask

  task automatic toggle_at(int half);
    while (cyc < last_cyc + half) @(negedge clk);
    dco_in = ~dco_in;
    if (armed) exp_q.push_back(cyc - last_cyc - 1);
    armed    = 1;
    last_cyc = cyc;
  endtask

  task automatic disarm();
    armed     = 0;
    have_prev = 0;
  endtask

  task automatic wait_strobe(output bit got);
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = (meas_strobe === 1'b1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({period_out, code_out, code_valid, locked, meas_strobe, bad_period,
         stalled} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, need 0",
               {period_out, code_out, code_valid, locked, meas_strobe,
                bad_period, stalled});
    end
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lock_p10();
    repeat (4) toggle_at(11);
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({period_out, code_out, locked, code_valid} !== {8'd10, 8'h80, 2'b11}) begin
      n_bad++;
      $display("FAIL lock_p10: got P=%0d code=%h lk=%b cv=%b, need 10 80 1 1",
               period_out, code_out, locked, code_valid);
    end
  endtask

  task automatic test_code_p3();
    repeat (4) toggle_at(4);
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({period_out, code_out, locked, code_valid} !== {8'd3, 8'h01, 2'b11}) begin
      n_bad++;
      $display("FAIL code_p3: got P=%0d code=%h lk=%b cv=%b, need 3 01 1 1",
               period_out, code_out, locked, code_valid);
    end
  endtask

  task automatic test_code_p0();
    repeat (4) toggle_at(51);
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({period_out, code_out, locked, code_valid} !== {8'd50, 8'h00, 2'b11}) begin
      n_bad++;
      $display("FAIL code_p0: got P=%0d code=%h lk=%b cv=%b, need 50 00 1 1",
               period_out, code_out, locked, code_valid);
    end
  endtask

  task automatic test_relock();
    bit got;
    repeat (3) toggle_at(11);
    wait_strobe(got);
    n_cmp++;
    if (!got || {code_out, locked} !== {8'h80, 1'b1}) begin
      n_bad++;
      $display("FAIL relock_pre: strobe=%b code=%h lk=%b, need 1 80 1",
               got, code_out, locked);
    end
    toggle_at(6);
    wait_strobe(got);
    n_cmp++;
    if (!got || {period_out, locked, code_valid} !== {8'd5, 2'b00}) begin
      n_bad++;
      $display("FAIL relock_first: strobe=%b P=%0d lk=%b cv=%b, need 1 5 0 0",
               got, period_out, locked, code_valid);
    end
    toggle_at(6);
    wait_strobe(got);
    n_cmp++;
    if (!got || {period_out, code_out, locked, code_valid} !==
        {8'd5, 8'h04, 2'b11}) begin
      n_bad++;
      $display("FAIL relock_second: strobe=%b P=%0d code=%h lk=%b cv=%b, need 1 5 04 1 1",
               got, period_out, code_out, locked, code_valid);
    end
  endtask

  task automatic test_bad_period();
    bit got;
    for (int i = 0; i < 3; i++) begin
      toggle_at(20);
      wait_strobe(got);
      n_cmp++;
      if (!got || {period_out, code_out, code_valid, bad_period} !==
          {8'd19, 8'h04, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL bad_period[%0d]: strobe=%b P=%0d code=%h cv=%b bad=%b, need 1 19 04 0 1",
                 i, got, period_out, code_out, code_valid, bad_period);
      end
    end
  endtask

  task automatic test_random();
    int halves[12] = '{4, 5, 6, 7, 8, 9, 10, 11, 51, 15, 30, 7};
    int h;
    for (int b = 0; b < 20; b++) begin
      h = halves[$urandom_range(0, 11)];
      repeat ($urandom_range(1, 4)) toggle_at(h);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain: %0d measurements missing, need 0",
               exp_q.size());
    end
  endtask

  task automatic test_stall();
    bit got;
    int s;
    repeat (3) toggle_at(11);
    wait_strobe(got);
    s = cyc;
    while (cyc < s + TO) @(negedge clk);
    n_cmp++;
    if (!got || stalled !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_early: strobe=%b stalled=%b, need 1 0", got, stalled);
    end
    @(negedge clk);
    n_cmp++;
    if ({stalled, locked, code_valid, period_out, code_out} !==
        {3'b100, 8'd10, 8'h80}) begin
      n_bad++;
      $display("FAIL stall_set: st=%b lk=%b cv=%b P=%0d code=%h, need 1 0 0 10 80",
               stalled, locked, code_valid, period_out, code_out);
    end
    disarm();
    toggle_at(1);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (stalled !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_clear: stalled=%b, need 0", stalled);
    end
  endtask

  task automatic test_en_drop();
    bit got;
    repeat (3) toggle_at(11);
    wait_strobe(got);
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!got || {locked, code_valid, period_out} !== {2'b00, 8'd10}) begin
      n_bad++;
      $display("FAIL en_drop: strobe=%b lk=%b cv=%b P=%0d, need 1 0 0 10",
               got, locked, code_valid, period_out);
    end
    disarm();
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (3) toggle_at(11);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL en_resume: lk=%b, need 1", locked);
    end
  endtask

  task automatic test_rst_mid();
    toggle_at(11);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({period_out, code_out, code_valid, locked, meas_strobe, bad_period,
         stalled} !== 21'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got %h, need 0",
               {period_out, code_out, code_valid, locked, meas_strobe,
                bad_period, stalled});
    end
    dco_in = 1'b0;
    exp_q.delete();
    disarm();
    last_code = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) toggle_at(11);
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({period_out, code_out, locked} !== {8'd10, 8'h80, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_recover: P=%0d code=%h lk=%b, need 10 80 1",
               period_out, code_out, locked);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    dco_in = 1'b0;
    fork
      mon_loop();
    join_none
    test_reset();
    test_lock_p10();
    test_code_p3();
    test_code_p0();
    test_relock();
    test_bad_period();
    test_random();
    test_stall();
    test_en_drop();
    test_rst_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: %0d measurements missing, need 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
